// File: rtl/prog_timer.sv
// prog_timer: programmable timestamp/sequence timer with wrap period,
// one-shot/periodic modes, synchronous preload and optional prescaler.
//
// Optional feature macro: PROG_TIMER_PRESCALER_EN
//   defined   - tick every presc_div+1 enabled cycles
//   undefined - no prescaler register, tick every enabled cycle,
//               presc_div is accepted but ignored
//
// Parameters:
//   WIDTH     counter / sample width (>= 2)
//   PRESC_W   prescaler divider width (>= 1)
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   t_en      count enable; low freezes counter and prescaler phase
//   mode      0 = periodic, 1 = one-shot
//   period    terminal count; counter wraps after sampling it
//   presc_div tick every presc_div+1 enabled cycles
//   load      synchronous preload strobe (beats a coincident tick)
//   load_val  preload value
//   t_valid   one-cycle strobe, t_out holds a new sample
//   t_out     sampled (pre-increment) count, held between strobes
//   t_wrap    one-cycle strobe, the sample was the terminal count
//   t_done    level, one-shot completed; frozen until load or rst

module prog_timer #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t_en,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic               t_valid,
  output logic [WIDTH-1:0]   t_out,
  output logic               t_wrap,
  output logic               t_done
);

  logic [WIDTH-1:0] count;
  logic             presc_hit;
  logic             run;
  logic             tick;
  logic             at_term;

  // A completed one-shot freezes everything, prescaler included.
  assign run     = t_en & ~t_done;
  assign tick    = run & presc_hit;
  assign at_term = (count == period);

`ifdef PROG_TIMER_PRESCALER_EN

  logic [PRESC_W-1:0] pcnt;

  assign presc_hit = (pcnt == presc_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (load) begin
      pcnt <= '0;
    end else if (run) begin
      if (presc_hit) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESC_W'(1);
      end
    end
  end

`else

  logic unused_presc;

  assign presc_hit    = 1'b1;
  assign unused_presc = ^presc_div;

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      t_out   <= '0;
      t_valid <= 1'b0;
      t_wrap  <= 1'b0;
      t_done  <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      t_done  <= 1'b0;
      t_valid <= 1'b0;
      t_wrap  <= 1'b0;
    end else if (tick) begin
      t_out   <= count;
      t_valid <= 1'b1;
      if (at_term) begin
        count  <= '0;
        t_wrap <= 1'b1;
        if (mode) begin
          t_done <= 1'b1;
        end
      end else begin
        // Above period this free-rolls through all-ones to 0
        // without a wrap strobe.
        count  <= count + WIDTH'(1);
        t_wrap <= 1'b0;
      end
    end else begin
      t_valid <= 1'b0;
      t_wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed self-checking bench for prog_timer.
// Handles builds with or without PROG_TIMER_PRESCALER_EN.

module tb_prog_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk;
  logic          rst;
  logic          t_en;
  logic          mode;
  logic [W-1:0]  period;
  logic [PW-1:0] presc_div;
  logic          load;
  logic [W-1:0]  load_val;
  logic          t_valid;
  logic [W-1:0]  t_out;
  logic          t_wrap;
  logic          t_done;

  int checks;
  int errors;

  prog_timer #(
    .WIDTH  (W),
    .PRESC_W(PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_en     (t_en),
    .mode     (mode),
    .period   (period),
    .presc_div(presc_div),
    .load     (load),
    .load_val (load_val),
    .t_valid  (t_valid),
    .t_out    (t_out),
    .t_wrap   (t_wrap),
    .t_done   (t_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse released 1 time unit after an edge; the next edge
  // is the first counting edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    t_en      = 1'b0;
    mode      = 1'b0;
    period    = '1;
    presc_div = '0;
    load      = 1'b0;
    load_val  = '0;
    step();
    step();
    checks++;
    if (t_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", t_valid);
    end
    checks++;
    if (t_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out got %h want 0000", t_out);
    end
    checks++;
    if (t_wrap !== 1'b0 || t_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got wrap=%b done=%b want 0 0",
               t_wrap, t_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    int bad;
    int first_i;
    logic [W-1:0] exp_out;
    logic exp_wrap;
    bad     = 0;
    first_i = -1;
    t_en      = 1'b1;
    mode      = 1'b0;
    period    = 16'hFFFF;
    presc_div = '0;
    do_reset();
    for (int i = 0; i <= 65536; i++) begin
      step();
      exp_out  = W'(i);
      exp_wrap = (i == 65535);
      if (t_valid !== 1'b1 || t_out !== exp_out ||
          t_wrap !== exp_wrap || t_done !== 1'b0) begin
        bad++;
        if (first_i < 0) first_i = i;
      end
      if (i == 65535) begin
        checks++;
        if (t_out !== 16'hFFFF || t_wrap !== 1'b1) begin
          errors++;
          $display("FAIL free_top got out=%h wrap=%b want FFFF 1",
                   t_out, t_wrap);
        end
      end
      if (i == 65536) begin
        checks++;
        if (t_out !== 16'h0000 || t_wrap !== 1'b0) begin
          errors++;
          $display("FAIL free_roll got out=%h wrap=%b want 0000 0",
                   t_out, t_wrap);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL free_seq got %0d bad samples (first %0d) want 0",
               bad, first_i);
    end
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_out;
    t_en      = 1'b1;
    mode      = 1'b0;
    period    = 16'd3;
    presc_div = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      exp_out = W'(i % 4);
      checks++;
      if (t_valid !== 1'b1 || t_out !== exp_out ||
          t_wrap !== (exp_out == 16'd3) || t_done !== 1'b0) begin
        errors++;
        $display("FAIL periodic[%0d] got v=%b out=%0d wrap=%b done=%b want 1 %0d %b 0",
                 i, t_valid, t_out, t_wrap, t_done,
                 exp_out, (exp_out == 16'd3));
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_out;
    t_en      = 1'b1;
    mode      = 1'b1;
    period    = 16'd2;
    presc_div = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_out = W'(i);
      checks++;
      if (t_valid !== 1'b1 || t_out !== exp_out ||
          t_wrap !== (i == 2) || t_done !== (i == 2)) begin
        errors++;
        $display("FAIL oneshot[%0d] got v=%b out=%0d wrap=%b done=%b want 1 %0d %b %b",
                 i, t_valid, t_out, t_wrap, t_done, exp_out,
                 (i == 2), (i == 2));
      end
    end
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (t_valid !== 1'b0 || t_out !== 16'd2 ||
          t_wrap !== 1'b0 || t_done !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_hold[%0d] got v=%b out=%0d wrap=%b done=%b want 0 2 0 1",
                 i, t_valid, t_out, t_wrap, t_done);
      end
    end
    mode     = 1'b1;
    load     = 1'b1;
    load_val = 16'd5;
    step();
    load = 1'b0;
    checks++;
    if (t_done !== 1'b0 || t_valid !== 1'b0 || t_out !== 16'd2) begin
      errors++;
      $display("FAIL oneshot_load got done=%b v=%b out=%0d want 0 0 2",
               t_done, t_valid, t_out);
    end
    step();
    checks++;
    if (t_valid !== 1'b1 || t_out !== 16'd5) begin
      errors++;
      $display("FAIL oneshot_reload got v=%b out=%0d want 1 5",
               t_valid, t_out);
    end
  endtask

  task automatic test_prescaler();
    // en/valid patterns for 19 consecutive cycles after reset.
    logic [18:0] en_pat;
    logic [18:0] v_pat;
    logic [W-1:0] exp_out;
    mode      = 1'b0;
    period    = 16'hFFFF;
    presc_div = 8'd2;
    t_en      = 1'b1;
`ifdef PROG_TIMER_PRESCALER_EN
    en_pat = 19'b1111100001111111111;
    v_pat  = 19'b1001000000100100100;
`else
    en_pat = 19'b1111100001111111111;
    v_pat  = 19'b1111100001111111111;
`endif
    exp_out = '0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      t_en = en_pat[i];
      step();
      checks++;
      if (t_valid !== v_pat[i] ||
          (v_pat[i] && t_out !== exp_out)) begin
        errors++;
        $display("FAIL presc[%0d] got v=%b out=%0d want v=%b out=%0d",
                 i, t_valid, t_out, v_pat[i], exp_out);
      end
      if (v_pat[i]) exp_out = exp_out + 16'd1;
    end
    t_en = 1'b1;
  endtask

  task automatic test_collision();
    t_en      = 1'b1;
    mode      = 1'b0;
    period    = 16'hFFFF;
    presc_div = '0;
    do_reset();
    step();
    step();
    step();
    load     = 1'b1;
    load_val = 16'd10;
    step();
    load = 1'b0;
    checks++;
    if (t_valid !== 1'b0 || t_wrap !== 1'b0 || t_out !== 16'd2) begin
      errors++;
      $display("FAIL collide got v=%b wrap=%b out=%0d want 0 0 2",
               t_valid, t_wrap, t_out);
    end
    step();
    checks++;
    if (t_valid !== 1'b1 || t_out !== 16'd10) begin
      errors++;
      $display("FAIL collide_next got v=%b out=%0d want 1 10",
               t_valid, t_out);
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] exp_out [13];
    logic         exp_wrap [13];
    exp_out = '{16'h000A, 16'h000B, 16'hFFFC, 16'hFFFD, 16'hFFFE,
                16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003,
                16'h0004, 16'h0000, 16'h0001};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    period = 16'd4;
    load     = 1'b1;
    load_val = 16'd10;
    step();
    load = 1'b0;
    for (int i = 0; i < 13; i++) begin
      // Jump to the top of the range after two samples above period.
      if (i == 2) begin
        load     = 1'b1;
        load_val = 16'hFFFC;
        step();
        load = 1'b0;
      end
      step();
      checks++;
      if (t_valid !== 1'b1 || t_out !== exp_out[i] ||
          t_wrap !== exp_wrap[i]) begin
        errors++;
        $display("FAIL range[%0d] got v=%b out=%h wrap=%b want 1 %h %b",
                 i, t_valid, t_out, t_wrap, exp_out[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    t_en      = 1'b1;
    mode      = 1'b0;
    period    = 16'hFFFF;
    presc_div = '0;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (t_out !== 16'd6 || t_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got out=%0d v=%b want 6 1", t_out, t_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (t_out !== 16'd0 || t_valid !== 1'b0 ||
        t_wrap !== 1'b0 || t_done !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got out=%0d v=%b wrap=%b done=%b want 0 0 0 0",
               t_out, t_valid, t_wrap, t_done);
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (t_out !== 16'd0 || t_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_first got out=%0d v=%b want 0 1",
               t_out, t_valid);
    end
    step();
    checks++;
    if (t_out !== 16'd1) begin
      errors++;
      $display("FAIL arst_second got out=%0d want 1", t_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_prescaler();
    test_collision();
    test_out_of_range();
    test_async_reset();
    test_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
